lives_tracker: RTL and testbench

//   Produces LivesCount, the lives input that GameControl_top consumes to decide game-over.

---
 rtl/lives_if.sv | 19 +
 rtl/lives_tracker.sv | 96 +++++++++
 tb/tb_lives_tracker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lives_if.sv
// lives_if: game-control, frame, miss and lives/status signals of lives_tracker
interface lives_if;
  logic       Game_Enable;
  logic       GameTimer_Reset;
  logic       VMA_busy;
  logic       ballMissed;
  logic [1:0] LivesCount;
  logic       Ball_Enable;
  logic       Respawn_Active;
  logic       GameOver;
  modport master (
    output Game_Enable, GameTimer_Reset, VMA_busy, ballMissed,
    input  LivesCount, Ball_Enable, Respawn_Active, GameOver
  );
  modport slave (
    input  Game_Enable, GameTimer_Reset, VMA_busy, ballMissed,
    output LivesCount, Ball_Enable, Respawn_Active, GameOver
  );
endinterface

// File: rtl/lives_tracker.sv
// lives_tracker: counts lives on ball misses and holds the ball off for a frame-counted respawn
module lives_tracker #(
  parameter int START_LIVES    = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int FRAME_CNT_W    = 6
) (
  input logic   Clk_100MHz,
  input logic   Reset,
  lives_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, RESPAWN, OVER} state_t;
  localparam logic [1:0]             START = 2'(START_LIVES);
  localparam logic [FRAME_CNT_W-1:0] LAST  = FRAME_CNT_W'(RESPAWN_FRAMES - 1);
  state_t                 r_state, w_state;
  logic [1:0]             r_lives, w_lives;
  logic [FRAME_CNT_W-1:0] r_cnt, w_cnt;
  logic                   r_ball, w_ball, r_resp, w_resp, r_over, w_over;
  logic                   r_vprev, r_mprev, w_tick, w_miss;
  assign bus.LivesCount     = r_lives;
  assign bus.Ball_Enable    = r_ball;
  assign bus.Respawn_Active = r_resp;
  assign bus.GameOver       = r_over;
  // next state, lives, counter and flags; new-game request overrides every state
  always_comb begin
    w_tick  = bus.VMA_busy & ~r_vprev;
    w_miss  = bus.ballMissed & ~r_mprev;
    w_state = r_state;
    w_lives = r_lives;
    w_cnt   = r_cnt;
    w_ball  = 1'b0;
    w_resp  = 1'b0;
    w_over  = 1'b0;
    if (bus.GameTimer_Reset) begin
      w_state = IDLE;
      w_lives = START;
      w_cnt   = '0;
    end else begin
      case (r_state)
        IDLE: if (bus.Game_Enable) begin
          w_state = PLAY;
          w_ball  = 1'b1;
        end
        PLAY: if (w_miss & bus.Game_Enable) begin
          if (r_lives > 2'd1) begin
            w_lives = r_lives - 2'd1;
            w_state = RESPAWN;
            w_cnt   = '0;
            w_resp  = 1'b1;
          end else begin
            w_lives = 2'd0;
            w_state = OVER;
            w_over  = 1'b1;
          end
        end else w_ball = bus.Game_Enable;
        RESPAWN: begin
          w_resp = 1'b1;
          if (w_tick & bus.Game_Enable) begin
            if (r_cnt == LAST) begin
              w_state = PLAY;
              w_cnt   = '0;
              w_resp  = 1'b0;
              w_ball  = 1'b1;
            end else w_cnt = r_cnt + 1'b1;
          end
        end
        OVER: begin
          w_over  = 1'b1;
          w_lives = 2'd0;
        end
        default: w_state = IDLE;
      endcase
    end
  end
  // state, outputs and edge-detect history, cleared immediately by reset
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_lives <= START;
      r_cnt   <= '0;
      r_ball  <= 1'b0;
      r_resp  <= 1'b0;
      r_over  <= 1'b0;
      r_vprev <= 1'b0;
      r_mprev <= 1'b0;
    end else begin
      r_state <= w_state;
      r_lives <= w_lives;
      r_cnt   <= w_cnt;
      r_ball  <= w_ball;
      r_resp  <= w_resp;
      r_over  <= w_over;
      r_vprev <= bus.VMA_busy;
      r_mprev <= bus.ballMissed;
    end
  end
endmodule

// File: tb/tb_lives_tracker.sv
// tb_lives_tracker: directed scenarios plus random play checked against a lives/respawn model
module tb_lives_tracker;
  localparam int START = 3;
  localparam int RF    = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_lives, m_left;
  bit   m_started, m_ball, m_vprev, m_mprev;
  lives_if bus ();
  lives_tracker #(.START_LIVES(START), .RESPAWN_FRAMES(RF), .FRAME_CNT_W(3)) dut (
    .Clk_100MHz(clk),
    .Reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask
  task automatic m_reset();
    m_lives = START;
    m_left = 0;
    m_started = 0;
    m_ball = 0;
    m_vprev = 0;
    m_mprev = 0;
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_lives"}, int'(bus.LivesCount), m_lives);
    chk({tag, "_ball"}, int'(bus.Ball_Enable), int'(m_ball));
    chk({tag, "_resp"}, int'(bus.Respawn_Active), int'(m_left > 0));
    chk({tag, "_over"}, int'(bus.GameOver), int'(m_started && m_lives == 0));
  endtask
  task automatic step(input bit ge, input bit gtr, input bit vb, input bit bm);
    bit tick, miss;
    bus.Game_Enable = ge;
    bus.GameTimer_Reset = gtr;
    bus.VMA_busy = vb;
    bus.ballMissed = bm;
    @(posedge clk);
    tick = vb && !m_vprev;
    miss = bm && !m_mprev;
    m_vprev = vb;
    m_mprev = bm;
    if (gtr) begin
      m_lives = START;
      m_left = 0;
      m_started = 0;
      m_ball = 0;
    end else if (!m_started) m_ball = ge;
    else if (m_lives == 0) m_ball = 0;
    else if (m_left > 0) begin
      if (tick && ge) m_left--;
      m_ball = (m_left == 0);
    end else if (miss && ge) begin
      m_lives--;
      m_left = (m_lives > 0) ? RF : 0;
      m_ball = 0;
    end else m_ball = ge;
    if (!gtr && !m_started && ge) m_started = 1;
    #1;
    check_all("step");
  endtask
  task automatic pulse(input bit ge);
    step(ge, 0, 1, 0);
    step(ge, 0, 0, 0);
  endtask
  initial begin
    bus.Game_Enable = 0;
    bus.GameTimer_Reset = 0;
    bus.VMA_busy = 0;
    bus.ballMissed = 0;
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_lives", int'(bus.LivesCount), 3);
    chk("rst_ball", int'(bus.Ball_Enable), 0);
    chk("rst_resp", int'(bus.Respawn_Active), 0);
    chk("rst_over", int'(bus.GameOver), 0);
    rst = 0;
    step(1, 0, 0, 0);
    chk("t1_play_ball", int'(bus.Ball_Enable), 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
    chk("t2_lives", int'(bus.LivesCount), 2);
    chk("t2_resp", int'(bus.Respawn_Active), 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < RF - 1; i++) pulse(1);
    chk("t3_before4", int'(bus.Ball_Enable), 0);
    step(1, 0, 1, 0);
    chk("t3_after4", int'(bus.Ball_Enable), 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("t4_lives1", int'(bus.LivesCount), 1);
    step(1, 0, 0, 0);
    pulse(1);
    pulse(0);
    pulse(0);
    pulse(1);
    pulse(1);
    chk("t3_paused_5", int'(bus.Ball_Enable), 0);
    step(1, 0, 1, 0);
    chk("t3_paused_6", int'(bus.Ball_Enable), 1);
    step(1, 0, 0, 1);
    chk("t4_over", int'(bus.GameOver), 1);
    chk("t4_lives0", int'(bus.LivesCount), 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("t4_no_underflow", int'(bus.LivesCount), 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    chk("t5_lives", int'(bus.LivesCount), 3);
    chk("t5_over", int'(bus.GameOver), 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    pulse(1);
    chk("t6_in_resp", int'(bus.Respawn_Active), 1);
    #2 rst = 1;
    #1;
    chk("t6_lives", int'(bus.LivesCount), 3);
    chk("t6_resp", int'(bus.Respawn_Active), 0);
    chk("t6_ball", int'(bus.Ball_Enable), 0);
    m_reset();
    @(posedge clk);
    #1 rst = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    for (int i = 0; i < RF - 1; i++) pulse(1);
    chk("t6_cnt_cleared", int'(bus.Ball_Enable), 0);
    step(1, 0, 1, 0);
    chk("t6_full_respawn", int'(bus.Ball_Enable), 1);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
